bkm_iter_ctrl: RTL and testbench

- Folded-iteration sequencer for one registered bkm_step instance.
- Accepts a start request with initial operands, mode and format.
- Runs N iterations: drives iteration index n, digit pair d_n, the step enable and the operand mux (initial values or step feedback).
- Captures final X/Y/u/v and pulses done; sits between the FPU front-end and the bkm_step / LUT / bin2csd–csd2bin wrappers.

---
 rtl/bkm_pkg.sv | 32 +++
 rtl/bkm_digit_sel.sv | 35 +++
 rtl/bkm_iter_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bkm_iter_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM iteration sequencer.
//   state_e    : sequencer FSM states
//   DIG_*      : signed-digit encodings used on step_d_n
//   MODE_*     : operation mode (E = exponential, L = logarithm)
//   dig_neg()  : negate an encoded digit
package bkm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] DIG_P1 = 2'b01;
  localparam logic [1:0] DIG_Z  = 2'b00;
  localparam logic [1:0] DIG_M1 = 2'b11;

  localparam logic MODE_E = 1'b0;
  localparam logic MODE_L = 1'b1;

  function automatic logic [1:0] dig_neg(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      DIG_P1:  r = DIG_M1;
      DIG_M1:  r = DIG_P1;
      default: r = DIG_Z;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bkm_digit_sel.sv
// Combinational BKM digit selection.
//   operand : W-bit two's complement operand feeding the decision
//   mode    : MODE_E or MODE_L; L-mode negates the chosen digit
//   digit   : encoded digit (DIG_P1 / DIG_Z / DIG_M1)
// The decision looks only at the top three bits of the operand, read as a
// signed value t: t >= 1 -> +1, t in {0,-1} -> 0, t <= -2 -> -1.
module bkm_digit_sel
  import bkm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0] operand,
  input  logic                mode,
  output logic [1:0]          digit
);

  logic signed [2:0] t;
  logic [1:0]        raw;
  logic              unused_lsbs;

  assign t           = operand[W-1:W-3];
  assign unused_lsbs = ^operand[W-4:0];

  always_comb begin
    raw = DIG_Z;
    if (t >= 3'sd1) begin
      raw = DIG_P1;
    end else if (t <= -3'sd2) begin
      raw = DIG_M1;
    end
  end

  assign digit = (mode == MODE_L) ? dig_neg(raw) : raw;

endmodule

// File: rtl/bkm_iter_ctrl.sv
// Folded-iteration sequencer for a single registered bkm_step instance.
// Accepts an operation in IDLE, runs N step iterations (ITER), captures the
// final step outputs (LAST) and pulses done for one enabled cycle (DONE).
//   clk, arst, srst, enable        : clock, async reset, sync reset, clock enable
//   start, mode_in, format_in      : operation request and its attributes
//   X0/Y0/u0/v0                    : initial operands
//   X_fb/Y_fb/u_fb/v_fb            : registered step outputs (1 cycle after step_ena)
//   busy, done                     : status; done is a one-cycle result strobe
//   step_ena/mode/format/n/d_n     : controls driven to bkm_step and its LUT
//   op_X/op_Y/op_u/op_v            : operands presented to bkm_step
//   X_res/Y_res/u_res/v_res        : final results, held until the next done
module bkm_iter_ctrl
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    srst,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    mode_in,
  input  logic [1:0]              format_in,
  input  logic signed [W-1:0]     X0,
  input  logic signed [W-1:0]     Y0,
  input  logic signed [W-1:0]     u0,
  input  logic signed [W-1:0]     v0,
  input  logic signed [W-1:0]     X_fb,
  input  logic signed [W-1:0]     Y_fb,
  input  logic signed [W-1:0]     u_fb,
  input  logic signed [W-1:0]     v_fb,
  output logic                    busy,
  output logic                    done,
  output logic                    step_ena,
  output logic                    step_mode,
  output logic [1:0]              step_format,
  output logic [LOG2N-1:0]        step_n,
  output logic [3:0]              step_d_n,
  output logic signed [W-1:0]     op_X,
  output logic signed [W-1:0]     op_Y,
  output logic signed [W-1:0]     op_u,
  output logic signed [W-1:0]     op_v,
  output logic signed [W-1:0]     X_res,
  output logic signed [W-1:0]     Y_res,
  output logic signed [W-1:0]     u_res,
  output logic signed [W-1:0]     v_res
);

  if (LOG2W != $clog2(W)) begin : g_bad_log2w
    $error("bkm_iter_ctrl: LOG2W must equal clog2(W)");
  end
  if (LOG2N < $clog2(N)) begin : g_bad_log2n
    $error("bkm_iter_ctrl: LOG2N too small for N");
  end

  state_e                state, state_nxt;
  logic [LOG2N-1:0]      n;
  logic                  mode_r;
  logic [1:0]            fmt_r;
  logic signed [W-1:0]   x_init, y_init, u_init, v_init;
  logic                  use_fb;
  logic signed [W-1:0]   sel_dx, sel_dy;
  logic [1:0]            dig_x, dig_y;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_IDLE;
    end else if (enable) begin
      if (srst) begin
        state <= ST_IDLE;
      end else begin
        state <= state_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    step_ena  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ITER;
      end
      ST_ITER: begin
        step_ena = 1'b1;
        if (n == LOG2N'(N - 1)) state_nxt = ST_LAST;
      end
      ST_LAST: state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operation capture, iteration counter and result capture
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      n      <= '0;
      mode_r <= MODE_E;
      fmt_r  <= '0;
      x_init <= '0;
      y_init <= '0;
      u_init <= '0;
      v_init <= '0;
      X_res  <= '0;
      Y_res  <= '0;
      u_res  <= '0;
      v_res  <= '0;
    end else if (enable) begin
      if (srst) begin
        n      <= '0;
        mode_r <= MODE_E;
        fmt_r  <= '0;
        x_init <= '0;
        y_init <= '0;
        u_init <= '0;
        v_init <= '0;
        X_res  <= '0;
        Y_res  <= '0;
        u_res  <= '0;
        v_res  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              n      <= '0;
              mode_r <= mode_in;
              fmt_r  <= format_in;
              x_init <= X0;
              y_init <= Y0;
              u_init <= u0;
              v_init <= v0;
            end
          end
          ST_ITER: n <= n + LOG2N'(1);
          ST_LAST: begin
            X_res <= X_fb;
            Y_res <= Y_fb;
            u_res <= u_fb;
            v_res <= v_fb;
          end
          default: ;
        endcase
      end
    end
  end

  // Operand mux: iteration 0 uses the captured operands, later iterations
  // take the step feedback; outside ITER the captured values are shown.
  assign use_fb = (state == ST_ITER) && (n != '0);
  assign op_X   = use_fb ? X_fb : x_init;
  assign op_Y   = use_fb ? Y_fb : y_init;
  assign op_u   = use_fb ? u_fb : u_init;
  assign op_v   = use_fb ? v_fb : v_init;

  // E-mode decides on (u,v), L-mode on (Y,X)
  assign sel_dx = (mode_r == MODE_L) ? op_Y : op_u;
  assign sel_dy = (mode_r == MODE_L) ? op_X : op_v;

  bkm_digit_sel #(.W(W)) u_dig_x (
    .operand (sel_dx),
    .mode    (mode_r),
    .digit   (dig_x)
  );

  bkm_digit_sel #(.W(W)) u_dig_y (
    .operand (sel_dy),
    .mode    (mode_r),
    .digit   (dig_y)
  );

  assign step_d_n    = (state == ST_ITER) ? {dig_x, dig_y} : 4'b0000;
  assign step_n      = n;
  assign step_mode   = mode_r;
  assign step_format = fmt_r;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
module tb_bkm_iter_ctrl;

  localparam int W     = 8;
  localparam int LOG2W = 3;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic srst = 1'b0;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic mode_in = 1'b0;
  logic [1:0] format_in = '0;
  logic [W-1:0] X0 = '0, Y0 = '0, u0 = '0, v0 = '0;
  logic [W-1:0] X_fb = '0, Y_fb = '0, u_fb = '0, v_fb = '0;
  logic busy, done, step_ena, step_mode;
  logic [1:0] step_format;
  logic [LOG2N-1:0] step_n;
  logic [3:0] step_d_n;
  logic [W-1:0] op_X, op_Y, op_u, op_v, X_res, Y_res, u_res, v_res;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bkm_iter_ctrl #(.W(W), .LOG2W(LOG2W), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .mode_in(mode_in), .format_in(format_in),
    .X0(X0), .Y0(Y0), .u0(u0), .v0(v0),
    .X_fb(X_fb), .Y_fb(Y_fb), .u_fb(u_fb), .v_fb(v_fb),
    .busy(busy), .done(done), .step_ena(step_ena), .step_mode(step_mode),
    .step_format(step_format), .step_n(step_n), .step_d_n(step_d_n),
    .op_X(op_X), .op_Y(op_Y), .op_u(op_u), .op_v(op_v),
    .X_res(X_res), .Y_res(Y_res), .u_res(u_res), .v_res(v_res)
  );

  // Stand-in for bkm_step: a registered, iteration-dependent transform per channel
  function automatic logic [7:0] fstep(input int ch, input logic [7:0] x, input int k);
    logic [7:0] r;
    case (ch)
      0:       r = 8'(x * 3 + k + 1);
      1:       r = x ^ 8'(8'h35 + k);
      2:       r = 8'(x + 8'h27 - k);
      default: r = {x[6:0], x[7]} ^ 8'(k * 17);
    endcase
    return r;
  endfunction

  function automatic logic [7:0] ref_res(input int ch, input logic [7:0] x0);
    logic [7:0] x;
    x = x0;
    for (int k = 0; k < N; k++) x = fstep(ch, x, k);
    return x;
  endfunction

  // Digit rule in plain arithmetic: top 3 bits as a signed value
  function automatic logic [1:0] ref_dig(input logic [7:0] op, input logic lmode);
    int v, t, d;
    v = $signed(op);
    t = v >>> (W - 3);
    if (t >= 1) d = 1;
    else if (t >= -1) d = 0;
    else d = -1;
    if (lmode) d = -d;
    return (d == 1) ? 2'b01 : ((d == -1) ? 2'b11 : 2'b00);
  endfunction

  always @(posedge clk) begin
    if (enable && step_ena) begin
      X_fb <= fstep(0, op_X, int'(step_n));
      Y_fb <= fstep(1, op_Y, int'(step_n));
      u_fb <= fstep(2, op_u, int'(step_n));
      v_fb <= fstep(3, op_v, int'(step_n));
    end
  end

  // Reference model: m_c counts enabled cycles since acceptance
  // (1..N iterating, N+1 capturing, N+2 done).
  bit         m_active = 1'b0;
  int         m_c = 0;
  logic       m_mode = 1'b0;
  logic [1:0] m_fmt = '0;
  logic [7:0] m_init[4] = '{default: '0};
  logic [7:0] m_val[4]  = '{default: '0};
  logic [7:0] m_res[4]  = '{default: '0};

  task automatic model_clear();
    m_active = 1'b0;
    m_c = 0;
    m_mode = 1'b0;
    m_fmt = '0;
    for (int i = 0; i < 4; i++) begin
      m_init[i] = '0;
      m_val[i] = '0;
      m_res[i] = '0;
    end
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      model_clear();
    end else if (enable) begin
      if (srst) begin
        model_clear();
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_c = 1;
          m_mode = mode_in;
          m_fmt = format_in;
          m_init[0] = X0; m_init[1] = Y0; m_init[2] = u0; m_init[3] = v0;
          for (int i = 0; i < 4; i++) m_val[i] = m_init[i];
        end
      end else begin
        if (m_c <= N) begin
          for (int i = 0; i < 4; i++) m_val[i] = fstep(i, m_val[i], m_c - 1);
        end else if (m_c == N + 1) begin
          for (int i = 0; i < 4; i++) m_res[i] = m_val[i];
        end
        if (m_c == N + 2) m_active = 1'b0;
        else m_c++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    logic [7:0] eop[4];
    bit iter;
    logic [1:0] edx, edy;
    iter = m_active && (m_c >= 1) && (m_c <= N);
    for (int i = 0; i < 4; i++) eop[i] = iter ? m_val[i] : m_init[i];
    edx = ref_dig(m_mode ? eop[1] : eop[2], m_mode);
    edy = ref_dig(m_mode ? eop[0] : eop[3], m_mode);
    check("busy", busy, m_active);
    check("done", done, m_active && (m_c == N + 2));
    check("step_ena", step_ena, iter);
    if (iter) check("step_n", step_n, m_c - 1);
    check("step_d_n", step_d_n, iter ? {edx, edy} : 4'b0000);
    check("step_mode", step_mode, m_mode);
    check("step_format", step_format, m_fmt);
    check("op_X", op_X, eop[0]);
    check("op_Y", op_Y, eop[1]);
    check("op_u", op_u, eop[2]);
    check("op_v", op_v, eop[3]);
    check("X_res", X_res, m_res[0]);
    check("Y_res", Y_res, m_res[1]);
    check("u_res", u_res, m_res[2]);
    check("v_res", v_res, m_res[3]);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] u,
                          input logic [7:0] v, input logic m, input logic [1:0] f);
    X0 = x; Y0 = y; u0 = u; v0 = v; mode_in = m; format_in = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first ITER cycle; returns cycles from start to done, ends in IDLE
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    bit saw;
    #1 arst = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_X", op_X, 0);
    check("rst_step_n", step_n, 0);
    check("rst_X_res", X_res, 0);
    tick(); tick();
    arst = 1'b0;
    tick();

    start_op(8'h40, 8'h00, 8'h20, 8'h00, 1'b0, 2'd0);
    check("first_busy", busy, 1);
    check("first_n", step_n, 0);
    check("first_dn", step_d_n, 4'b0100);
    wait_done(lat);
    check("latency", lat, 10);
    check("first_X_res", X_res, ref_res(0, 8'h40));
    check("first_u_res", u_res, ref_res(2, 8'h20));

    start_op(8'h00, 8'h00, 8'h60, 8'hC0, 1'b0, 2'd1);
    check("dn_E", step_d_n, 4'b0111);
    wait_done(lat);
    start_op(8'hC0, 8'h60, 8'h00, 8'h00, 1'b1, 2'd2);
    check("dn_L", step_d_n, 4'b1101);
    wait_done(lat);
    start_op(8'h00, 8'h00, 8'hE0, 8'h80, 1'b0, 2'd0);
    check("dn_bound_a", step_d_n, 4'b0011);
    wait_done(lat);
    start_op(8'h00, 8'h00, 8'h80, 8'h1F, 1'b0, 2'd3);
    check("dn_bound_b", step_d_n, 4'b1100);
    wait_done(lat);

    // start held high: one operation per N+3 cycles
    X0 = 8'h5A; Y0 = 8'hA5; u0 = 8'h3C; v0 = 8'hC3;
    start = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (done !== 1'b1 && cnt < 40);
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      do begin tick(); cnt++; end while (done !== 1'b1 && cnt < 40);
      check("interval", cnt, 11);
    end
    start = 1'b0;
    tick();

    // enable low for 3 cycles at n=4, then stretch done
    start_op(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 2'd0);
    lat = 1;
    while (step_n != 3'd4 && lat < 20) begin tick(); lat++; end
    enable = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick(); lat++;
      check("frozen_n", step_n, 4);
    end
    enable = 1'b1;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    check("freeze_latency", lat, 13);
    check("freeze_X_res", X_res, ref_res(0, 8'h11));
    enable = 1'b0;
    tick();
    check("done_stretch", done, 1);
    enable = 1'b1;
    tick();
    check("done_after", done, 0);

    // arst in the middle of an operation
    start_op(8'h77, 8'h12, 8'h34, 8'h56, 1'b1, 2'd2);
    cnt = 0;
    while (step_n != 3'd5 && cnt < 20) begin tick(); cnt++; end
    arst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_X_res", X_res, 0);
    tick();
    arst = 1'b0;
    saw = 1'b0;
    repeat (15) begin tick(); if (done === 1'b1) saw = 1'b1; end
    check("abort_no_done", saw, 0);

    // srst wins over start
    X0 = 8'h7F;
    srst = 1'b1; start = 1'b1;
    tick();
    srst = 1'b0; start = 1'b0;
    check("srst_idle", busy, 0);
    check("srst_no_capture", op_X, 0);
    tick();
    check("srst_idle2", busy, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      arst      = ($urandom % 250) == 0;
      enable    = ($urandom % 8) != 0;
      start     = ($urandom % 3) == 0;
      srst      = ($urandom % 64) == 0;
      mode_in   = 1'($urandom);
      format_in = 2'($urandom);
      X0 = 8'($urandom); Y0 = 8'($urandom); u0 = 8'($urandom); v0 = 8'($urandom);
      tick();
    end
    arst = 1'b0; srst = 1'b0; start = 1'b0; enable = 1'b1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
